// File: rtl/sd_dump_pkg.sv
// Shared types and constants for the multi-sector SD dump controller.
// Holds the FSM state encoding and the sector geometry.
package sd_dump_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned SECTOR_W     = 32;
    localparam int unsigned SECTOR_AW    = $clog2(SECTOR_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_ERR   = 2'd3
    } dump_state_t;

    function automatic logic in_window(input logic [SECTOR_AW-1:0] addr,
                                       input int unsigned          off,
                                       input int unsigned          len);
        return (32'(addr) >= off) && (32'(addr) < off + len);
    endfunction

endpackage

// File: rtl/sd_sector_dump_ctrl_if.sv
// Handshake and byte stream between the dump controller and the SPI sector reader.
// master = controller side, slave = reader side.
interface sd_sector_dump_ctrl_if;
    import sd_dump_pkg::*;

    logic                 rd_start;
    logic [SECTOR_W-1:0]  rd_sector_no;
    logic                 rd_done;
    logic                 rvalid;
    logic [SECTOR_AW-1:0] raddr;
    logic [7:0]           rdata;

    modport master (
        output rd_start,
        output rd_sector_no,
        input  rd_done,
        input  rvalid,
        input  raddr,
        input  rdata
    );

    modport slave (
        input  rd_start,
        input  rd_sector_no,
        output rd_done,
        output rvalid,
        output raddr,
        output rdata
    );

endinterface

// File: rtl/sd_dump_capture_buf.sv
// Two-bank byte window: one bank is filled while the other is shown.
// A swap flips roles, so the read port only ever exposes a complete window.
module sd_dump_capture_buf #(
    parameter  int unsigned WIN_BYTES = 8,
    localparam int unsigned AW        = (WIN_BYTES > 1) ? $clog2(WIN_BYTES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_swap,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [WIN_BYTES-1:0][7:0] r_bank0;
    logic [WIN_BYTES-1:0][7:0] r_bank1;
    logic                      r_wbank;
    logic [7:0]                r_rdata;
    logic                      w_wr_ok;
    logic                      w_rd_ok;

    assign w_wr_ok = (32'(i_waddr) < WIN_BYTES);
    assign w_rd_ok = (32'(i_raddr) < WIN_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank0 <= '0;
            r_bank1 <= '0;
            r_wbank <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            if (i_we && w_wr_ok) begin
                if (r_wbank) begin
                    r_bank1[i_waddr] <= i_wdata;
                end else begin
                    r_bank0[i_waddr] <= i_wdata;
                end
            end
            if (i_swap) begin
                r_wbank <= ~r_wbank;
            end
            // Read side always uses the bank that is not being written.
            if (!w_rd_ok) begin
                r_rdata <= 8'h00;
            end else if (r_wbank) begin
                r_rdata <= r_bank0[i_raddr];
            end else begin
                r_rdata <= r_bank1[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sd_sector_dump_ctrl.sv
// Walks a range of consecutive sectors through the SPI reader, single-pass or looping,
// capturing a byte window from each into a ping-pong buffer, with a per-sector watchdog.
module sd_sector_dump_ctrl
    import sd_dump_pkg::*;
#(
    parameter  int unsigned WIN_OFFSET = 504,
    parameter  int unsigned WIN_BYTES  = 8,
    parameter  int unsigned TIMEOUT    = 50_000_000,
    localparam int unsigned VA_W       = (WIN_BYTES > 1) ? $clog2(WIN_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [SECTOR_W-1:0]   i_req_sector,
    input  logic [15:0]           i_req_count,
    input  logic                  i_mode_cont,
    input  logic                  i_abort,
    sd_sector_dump_ctrl_if.master rd_if,
    input  logic [VA_W-1:0]       i_view_addr,
    output logic [7:0]            o_view_data,
    output logic                  o_view_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [SECTOR_W-1:0]   o_cur_sector,
    output logic [15:0]           o_sec_cnt
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CC_W  = $clog2(WIN_BYTES + 1);

    dump_state_t         r_state;
    dump_state_t         w_state_nxt;
    logic [SECTOR_W-1:0] r_cur_sector;
    logic [SECTOR_W-1:0] w_cur_nxt;
    logic [15:0]         r_sec_cnt;
    logic [15:0]         w_cnt_nxt;
    logic [15:0]         w_cnt_inc;
    logic [SECTOR_W-1:0] r_req_sector;
    logic [15:0]         r_req_count;
    logic                r_mode_cont;
    logic                r_abort_pend;
    logic                w_abort_eff;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                w_accept;
    logic                w_swap;
    logic                w_enter_issue;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic                w_tmo_hit;
    logic [CC_W-1:0]     r_cap_cnt;
    logic [CC_W-1:0]     w_cap_inc;
    logic                w_cap_full;
    logic                w_hit;
    logic                r_view_valid;
    logic [VA_W-1:0]     w_waddr;

    assign w_cnt_inc   = r_sec_cnt + 16'd1;
    assign w_abort_eff = r_abort_pend | i_abort;
    assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    assign w_hit      = (r_state == ST_ISSUE) && rd_if.rvalid &&
                        in_window(rd_if.raddr, WIN_OFFSET, WIN_BYTES);
    assign w_waddr    = VA_W'(32'(rd_if.raddr) - WIN_OFFSET);
    // Saturate so a reader repeating addresses cannot wrap the byte count.
    assign w_cap_inc  = r_cap_cnt + CC_W'(w_hit && (r_cap_cnt != CC_W'(WIN_BYTES)));
    assign w_cap_full = (w_cap_inc == CC_W'(WIN_BYTES));

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_sector;
        w_cnt_nxt   = r_sec_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_accept    = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (i_req) begin
                    if (i_req_count != 16'd0) begin
                        w_state_nxt = ST_ISSUE;
                        w_cur_nxt   = i_req_sector;
                        w_cnt_nxt   = 16'd0;
                        w_err_nxt   = 1'b0;
                        w_accept    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (rd_if.rd_done) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_abort_eff) begin
                        // Aborted sector's window is dropped: no swap.
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_swap = w_cap_full;
                        if ((w_cnt_inc != r_req_count) || r_mode_cont) begin
                            w_state_nxt = ST_GAP;
                            if (w_cnt_inc == r_req_count) begin
                                w_cur_nxt = r_req_sector;
                                w_cnt_nxt = 16'd0;
                            end else begin
                                w_cur_nxt = r_cur_sector + 32'd1;
                            end
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_ERR;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_ISSUE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_enter_issue = (w_state_nxt == ST_ISSUE) && (r_state != ST_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cur_sector <= '0;
            r_sec_cnt    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_sector <= w_cur_nxt;
            r_sec_cnt    <= w_cnt_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Run parameters are frozen at acceptance; later req_* changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_sector <= '0;
            r_req_count  <= '0;
            r_mode_cont  <= 1'b0;
        end else if (w_accept) begin
            r_req_sector <= i_req_sector;
            r_req_count  <= i_req_count;
            r_mode_cont  <= i_mode_cont;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort_pend <= 1'b0;
        end else if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERR)) begin
            r_abort_pend <= 1'b0;
        end else if (i_abort && o_busy) begin
            r_abort_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt    <= '0;
            r_cap_cnt    <= '0;
            r_view_valid <= 1'b0;
        end else begin
            if (w_enter_issue) begin
                r_tmo_cnt <= '0;
                r_cap_cnt <= '0;
            end else begin
                if (r_state == ST_ISSUE) begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
                r_cap_cnt <= w_cap_inc;
            end
            if (w_swap) begin
                r_view_valid <= 1'b1;
            end
        end
    end

    sd_dump_capture_buf #(
        .WIN_BYTES (WIN_BYTES)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_hit),
        .i_waddr (w_waddr),
        .i_wdata (rd_if.rdata),
        .i_swap  (w_swap),
        .i_raddr (i_view_addr),
        .o_rdata (o_view_data)
    );

    assign rd_if.rd_start     = (r_state == ST_ISSUE);
    assign rd_if.rd_sector_no = r_cur_sector;
    assign o_busy             = (r_state == ST_ISSUE) || (r_state == ST_GAP);
    assign o_done             = r_done;
    assign o_err              = r_err;
    assign o_view_valid       = r_view_valid;
    assign o_cur_sector       = r_cur_sector;
    assign o_sec_cnt          = r_sec_cnt;

endmodule

// File: doc/sd_sector_dump_ctrl.md
# sd_sector_dump_ctrl

Multi-sector successor to the single-shot sector-0 capture logic in the board top. It drives the `sd_spi_sector_reader` start/sector_no/done handshake over a range of consecutive sectors, in single-pass or continuous mode. From each sector it captures a parametrised byte window into a ping-pong buffer, so the display side always sees one complete, coherent window. It adds a per-sector timeout watchdog.

## Interface
- `WIN_OFFSET`, 504: first captured byte address within a sector.
- `WIN_BYTES`, 8: number of captured bytes; `WIN_OFFSET+WIN_BYTES` ≤ 512, `WIN_BYTES` ≥ 1.
- `TIMEOUT`, 50_000_000: maximum clk cycles from `rd_start` rise to `rd_done`.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: one-cycle request pulse.
- `req_sector` in 32: first sector of the run.
- `req_count` in 16: number of sectors in the run.
- `mode_cont` in 1: 1 = wrap back to `req_sector` after `req_count` sectors, forever.
- `abort` in 1: one-cycle stop request.
- `rd_start` out 1: to the reader; held high until `rd_done`.
- `rd_sector_no` out 32: to the reader; stable while `rd_start` is high.
- `rd_done` in 1: one-cycle pulse from the reader.
- `rvalid` in 1: byte strobe from the reader.
- `raddr` in 9: byte address from the reader.
- `rdata` in 8: byte data from the reader.
- `view_addr` in clog2(WIN_BYTES): display-side byte select.
- `view_data` out 8: registered byte; index 0 = sector byte `WIN_OFFSET`.
- `view_valid` out 1: at least one complete window is available.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse when a single-pass run completes or an abort completes.
- `err` out 1: sticky timeout flag.
- `cur_sector` out 32: sector currently being read.
- `sec_cnt` out 16: sectors completed in the current pass.

## Operation
- States:
  - IDLE: waits for a request.
  - ISSUE: `rd_start`=1, `rd_sector_no` valid.
  - GAP: one cycle with `rd_start`=0 between sectors.
  - ERR: halted after a timeout.
- IDLE:
  - `req` with `req_count`≠0 → ISSUE; `cur_sector`←`req_sector`, `sec_cnt`←0, `err`←0.
  - `req` with `req_count`=0 → `done` pulse only; no read is issued.
- ISSUE:
  - `rd_done` → `sec_cnt`+1.
  - If more sectors remain, or `mode_cont`=1: → GAP, `cur_sector`+1 (mod 2^32).
  - Otherwise → IDLE with `done` pulse.
- Continuous wrap: when `sec_cnt` reaches `req_count`, `cur_sector`←`req_sector` and `sec_cnt`←0.
- GAP → ISSUE unconditionally.
- Timeout: a counter runs in ISSUE and clears on entry. If it reaches `TIMEOUT-1` with no `rd_done` → ERR; `rd_start`←0, `err`←1.
- ERR → IDLE on `req`; that request is accepted as a new run.
- `abort`:
  - Latched while busy; the current sector is allowed to finish.
  - At the next `rd_done`, the controller goes to IDLE with a `done` pulse, and the window from that sector is discarded (no bank swap).
  - `abort` in IDLE or ERR is ignored.
- `req` while busy is ignored. `req_*` and `mode_cont` are sampled only on acceptance.
- Capture:
  - When `rvalid` is high and `raddr` is in [WIN_OFFSET, WIN_OFFSET+WIN_BYTES), write `rdata` to the write bank at `raddr-WIN_OFFSET` and count the captured bytes.
  - On `rd_done` with the count = `WIN_BYTES`: swap banks and set `view_valid`.
  - Count < `WIN_BYTES` (short sector): no swap.
  - The count clears on every ISSUE entry.
- `view_valid` stays set until reset; buffer contents survive a new `req`.

## Timing
- Reset values:
  - `rd_start`, `done`, `err`, `busy`, `view_valid`: 0.
  - `rd_sector_no`, `cur_sector`, `sec_cnt`, `view_data`: 0.
  - State is IDLE; both buffer banks are 0.
- Run start and per-sector handshake:
  - `req` at cycle T → `rd_start`=1 and `busy`=1 at T+1, with `rd_sector_no`=`req_sector`.
  - `rd_done` at D → `rd_start`=0 at D+1 (GAP) → `rd_start`=1 at D+2 with the next sector number.
- Completion: on the last sector, `rd_done` at D → `done`=1 and `busy`=0 at D+1.
- Bank swap: takes effect at D+1; `view_data` reflects the new bank from D+2.
- `view_data` has 1-cycle latency from `view_addr`; an out-of-range `view_addr` returns 0.
- `busy` = state ≠ IDLE and state ≠ ERR.
- Reset asserted mid-run: every output returns to its reset value immediately; no `done` pulse.

## Structure
- Package `sd_dump_pkg` holds:
  - the state enum `dump_state_t`;
  - `SECTOR_BYTES`=512;
  - `SECTOR_W`=32.
- Sub-module `sd_dump_capture_buf` (parameter `WIN_BYTES`): two-bank byte RAM, with write-bank select, swap input and registered read port.
- The FSM, timeout counter and sector bookkeeping live in the top module.

## Test plan
- Single-pass run: `req_sector`=100, `req_count`=3 with a reader model → `rd_sector_no` sequence 100,101,102, each preceded by a 1-cycle GAP. `done` pulses once; `sec_cnt`=3.
- Window capture: default parameters, reader sends bytes `raddr[7:0]` → after swap, `view_addr` 0..7 returns 0xF8..0xFF, one cycle after each address.
- Continuous mode: `req_sector`=0xFFFF_FFFF, `req_count`=2 → sequence FFFF_FFFF, 0, FFFF_FFFF, 0…; `done` never pulses.
- Timeout: `TIMEOUT`=100 and the reader never returns `rd_done` → `err`=1 and `rd_start`=0 exactly 100 cycles after `rd_start` rose. A later `req` clears `err` and restarts the run.
- Abort: `abort` during sector 2 of 5 → sector 2 completes, `done` pulses, no further `rd_start`, and `view_data` still shows the sector 1 window.
- Edge requests:
  - `req_count`=0 → `done` at T+1 with no `rd_start`.
  - `req` while busy → ignored.
  - `rst_n` low mid-sector → all outputs return to 0 asynchronously.
